// File: rtl/ddr_app_arbiter.sv
// Two-requester round-robin front end for a DDR app (UI) port.
// Read responses are steered back to their requester through an in-order tag FIFO.
module ddr_app_arbiter #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                init_calib_complete,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic                req0_we,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic [DATA_W/8-1:0] req0_wmask,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic                req1_we,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wdata,
  input  logic [DATA_W/8-1:0] req1_wmask,
  output logic                rsp0_valid,
  output logic [DATA_W-1:0]   rsp0_rdata,
  output logic                rsp1_valid,
  output logic [DATA_W-1:0]   rsp1_rdata,
  output logic                app_en,
  output logic [2:0]          app_cmd,
  output logic [ADDR_W-1:0]   app_addr,
  input  logic                app_rdy,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid
);

  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [1:0] {CALIB, ARB, ISSUE} state_t;

  state_t             state;
  logic               prio;
  logic               cur_id;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   tag_count;
  logic [TAG_DEPTH-1:0] tag_mem;

  logic               tag_full;
  logic               elig0;
  logic               elig1;
  logic               grant;
  logic               grant_id;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [MASK_W-1:0]  sel_wmask;
  logic               cmd_accept;
  logic               data_accept;
  logic               issue_done;
  logic               push;
  logic               pop;
  logic               head_id;

  // A read may only be granted while there is room to remember its tag.
  assign tag_full = (tag_count == CNT_W'(TAG_DEPTH));
  assign elig0    = req0_valid && (req0_we || !tag_full);
  assign elig1    = req1_valid && (req1_we || !tag_full);
  assign grant    = (state == ARB) && init_calib_complete && (elig0 || elig1);
  assign grant_id = (elig0 && elig1) ? prio : elig1;

  assign req0_ready = grant && !grant_id;
  assign req1_ready = grant && grant_id;

  assign sel_we    = grant_id ? req1_we    : req0_we;
  assign sel_addr  = grant_id ? req1_addr  : req0_addr;
  assign sel_wdata = grant_id ? req1_wdata : req0_wdata;
  assign sel_wmask = grant_id ? req1_wmask : req0_wmask;

  // Command and write data handshake independently; a strobe already dropped counts as done.
  assign cmd_accept  = app_en && app_rdy;
  assign data_accept = app_wdf_wren && app_wdf_rdy;
  assign issue_done  = (state == ISSUE) && (!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy);

  assign push    = cmd_accept && (app_cmd == CMD_RD);
  assign pop     = app_rd_data_valid && (tag_count != '0);
  assign head_id = tag_mem[rd_ptr];

  assign rsp0_valid  = pop && !head_id;
  assign rsp1_valid  = pop && head_id;
  assign rsp0_rdata  = app_rd_data;
  assign rsp1_rdata  = app_rd_data;
  assign app_wdf_end = app_wdf_wren;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= CALIB;
      prio         <= 1'b0;
      cur_id       <= 1'b0;
      app_en       <= 1'b0;
      app_cmd      <= CMD_WR;
      app_addr     <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
    end else begin
      case (state)
        CALIB: begin
          if (init_calib_complete) state <= ARB;
        end
        ARB: begin
          if (!init_calib_complete) begin
            state <= CALIB;
          end else if (grant) begin
            state        <= ISSUE;
            prio         <= ~grant_id;
            cur_id       <= grant_id;
            app_en       <= 1'b1;
            app_cmd      <= sel_we ? CMD_WR : CMD_RD;
            app_addr     <= sel_addr;
            app_wdf_wren <= sel_we;
            app_wdf_data <= sel_wdata;
            app_wdf_mask <= sel_wmask;
          end
        end
        ISSUE: begin
          if (cmd_accept) app_en <= 1'b0;
          if (data_accept) app_wdf_wren <= 1'b0;
          // A calibration loss lets the current transaction finish, then parks.
          if (issue_done) state <= init_calib_complete ? ARB : CALIB;
        end
        default: state <= CALIB;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   tag_count <= tag_count + 1'b1;
        2'b01:   tag_count <= tag_count - 1'b1;
        default: tag_count <= tag_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) tag_mem[wr_ptr] <= cur_id;
  end

endmodule

// File: doc/ddr_app_arbiter.md
DDR_APP_ARBITER -- requirements
Module: ddr_app_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 28, DDR app byte-address width.
- DATA_W, 128, app data width; mask width is DATA_W/8.
- TAG_DEPTH, 16, number of outstanding reads; power of two.

REQ-002 Ports SHALL be, one per line:
- clock  in  1  single clock, the app UI clock.
- reset_n  in  1  reset, asynchronous, active-low.
- init_calib_complete  in  1  DDR calibration done.
- req0_valid / req1_valid  in  1  requester i has a command.
- req0_ready / req1_ready  out  1  requester i command captured.
- req0_we / req1_we  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  ADDR_W  byte address.
- req0_wdata / req1_wdata  in  DATA_W  write data.
- req0_wmask / req1_wmask  in  DATA_W/8  byte mask, 1 = masked off.
- rsp0_valid / rsp1_valid  out  1  read data for requester i; no backpressure.
- rsp0_rdata / rsp1_rdata  out  DATA_W  read data.
- app_en  out  1  command strobe.
- app_cmd  out  3  command: 000 = write, 001 = read.
- app_addr  out  ADDR_W  command address.
- app_rdy  in  1  command accepted when high with app_en.
- app_wdf_wren / app_wdf_end  out  1  write-data strobe; both always equal.
- app_wdf_data  out  DATA_W  write data.
- app_wdf_mask  out  DATA_W/8  write mask.
- app_wdf_rdy  in  1  write data accepted when high with wren.
- app_rd_data  in  DATA_W  read data.
- app_rd_data_valid  in  1  read data beat valid.

Function
REQ-003 FSM states SHALL be CALIB, ARB and ISSUE.
- CALIB -> ARB when init_calib_complete = 1.
- ARB -> ISSUE on a grant.
- ISSUE -> ARB when the transaction completes.

REQ-004 In ARB, a requester SHALL be eligible when its valid = 1 and, for a read, the tag FIFO is not full.

REQ-005 Grant SHALL be round-robin:
- Priority pointer resets to 0.
- After each grant, the pointer moves to the other requester.
- A single eligible requester is granted regardless of the pointer.

REQ-006 On grant, the arbiter SHALL assert the granted reqN_ready for exactly one cycle (the ARB cycle) and register we, addr, wdata, wmask and the requester ID.

REQ-007 In ISSUE, app_en SHALL hold 1 with app_cmd and app_addr from the registered request until the first cycle with app_rdy = 1.

REQ-008 For a write, app_wdf_wren and app_wdf_end SHALL hold 1 from ISSUE entry until the first cycle with app_wdf_rdy = 1. Command and data acceptance are tracked independently and may occur in either order or the same cycle.

REQ-009 ISSUE SHALL complete:
- For a read, on the cycle the command is accepted.
- For a write, on the cycle both command and data have been accepted.
- In both cases the FSM returns to ARB on the next cycle.
- Minimum grant-to-grant spacing is 2 cycles.

REQ-010 When a read command is accepted, the requester ID SHALL be pushed into the in-order tag FIFO (TAG_DEPTH entries).

REQ-011 On app_rd_data_valid = 1, the arbiter SHALL pop the FIFO head and assert rspN_valid for the popped ID in the same cycle (combinational, 0-cycle latency), with rspN_rdata = app_rd_data.
- The other rsp valid stays 0.
- rsp data buses may carry app_rd_data unconditionally.

REQ-012 A push and a pop in the same cycle SHALL leave occupancy unchanged. Pointers wrap modulo TAG_DEPTH.

REQ-013 app_rd_data_valid with an empty FIFO SHALL be dropped: no rsp valid is asserted and pointers are unchanged.

REQ-014 If init_calib_complete falls, the arbiter SHALL finish any ISSUE in progress, then enter CALIB and grant nothing further until calibration completes again.

Reset
REQ-015 Reset SHALL act asynchronously on assertion. After reset:
- state = CALIB, pointer = 0, FIFO empty.
- All ready, valid, app_en, app_wdf_wren and app_wdf_end outputs = 0.
- app_cmd = 000, app_addr = 0, data and mask outputs = 0.

REQ-016 Reset asserted mid-transaction SHALL abandon it, with no app_en held beyond the reset edge and outstanding read tags discarded.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- calib = 0, req0 read valid for 50 cycles -> no req0_ready, no app_en. Raise calib -> grant within 2 cycles, app_cmd = 001.
- req0 and req1 both writing continuously, app_rdy = app_wdf_rdy = 1 -> grants alternate 0,1,0,1; each app_en pulse carries the matching addr and data.
- Write with app_rdy delayed 3 cycles and app_wdf_rdy delayed 5 cycles -> app_en high exactly 4 cycles, wren high exactly 6 cycles, next grant no earlier than the cycle after data acceptance.
- 16 reads from req1 with no read data returned -> 17th read not granted while req0 writes are still granted. One app_rd_data_valid -> rsp1_valid and the 17th read is granted.
- Interleaved reads r0(A), r1(B), r0(C); return D1, D2, D3 -> rsp0 D1, rsp1 D2, rsp0 D3, in order.
- reset_n low during ISSUE with app_rdy = 0 -> app_en drops immediately. After release, state is CALIB and the FIFO is empty.
